gnn_layer_sched: RTL and testbench

- Time-multiplexed scheduler for the 4-node diamond GNN: edges 0-1, 0-2, 1-3, 2-3; each node's neighbourhood is self plus two neighbours.
- Replaces four parallel per-node layer instances with ONE shared layer engine.
- Latches a 16-feature input frame and forms aggregated operand vectors.
- Issues 8 engine jobs in order: layer 1 for nodes 0..3, then layer 2 for nodes 0..3. Buffers hidden results and presents the final 8 outputs with a completion strobe.

---
 rtl/gnn_layer_sched.sv | 155 +++++++++++++++
 tb/tb_gnn_layer_sched.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gnn_layer_sched.sv
// gnn_layer_sched: schedules the 8 jobs of a 2-layer, 4-node diamond GNN
// (edges 0-1, 0-2, 1-3, 2-3) onto one shared layer engine. It aggregates
// each node's operands over self plus two neighbours, buffers the hidden
// results and assembles the final 8 outputs.
module gnn_layer_sched #(
    parameter int TIMEOUT = 64,
    parameter int OPW     = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_ready,
    input  logic [79:0]      x_in,
    output logic             eng_req,
    output logic             eng_layer,
    output logic [4*OPW-1:0] eng_op,
    input  logic             eng_done,
    input  logic [51:0]      eng_res,
    output logic [159:0]     out_vec,
    output logic             out_valid,
    output logic             busy,
    output logic             err_timeout,
    output logic             err_overrun
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t            state, state_nx;
    logic              layer, layer_nx;
    logic [1:0]        node, node_nx;
    logic [CW-1:0]     wait_cnt;
    logic              timeout_hit;
    logic [79:0]       x_buf;
    logic signed [12:0] hidden [4][4];
    logic [4*OPW-1:0]  op_nx;

    // Next-state logic: job sequencing over (layer, node) and WAIT timeout
    always_comb begin
        state_nx    = state;
        layer_nx    = layer;
        node_nx     = node;
        timeout_hit = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (in_ready) begin
                    state_nx = S_ISSUE;
                    layer_nx = 1'b0;
                    node_nx  = 2'd0;
                end
            end
            S_ISSUE: state_nx = S_WAIT;
            S_WAIT: begin
                if (eng_done) begin
                    if (node != 2'd3) begin
                        node_nx  = node + 2'd1;
                        state_nx = S_ISSUE;
                    end else if (!layer) begin
                        layer_nx = 1'b1;
                        node_nx  = 2'd0;
                        state_nx = S_ISSUE;
                    end else begin
                        state_nx = S_DONE;
                    end
                end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    state_nx    = S_IDLE;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Operand formation for the job about to be issued. N(n) is every node
    // except 3-n. The first job reads x_in directly because x_buf is only
    // being loaded in that same cycle.
    always_comb begin
        logic [79:0]        frame;
        logic [1:0]         excl;
        logic signed [6:0]  xs;
        logic signed [14:0] hs;
        op_nx = '0;
        frame = (state == S_IDLE) ? x_in : x_buf;
        excl  = 2'd3 - node_nx;
        for (int unsigned f = 0; f < 4; f++) begin
            xs = '0;
            hs = '0;
            for (int unsigned m = 0; m < 4; m++) begin
                if (2'(m) != excl) begin
                    xs = xs + 7'($signed(frame[(m*4+f)*5 +: 5]));
                    hs = hs + 15'(hidden[m][f]);
                end
            end
            op_nx[f*OPW +: OPW] = layer_nx ? OPW'(hs) : OPW'(xs);
        end
    end

    // Control registers, operand register, output vector and sticky errors
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            layer       <= 1'b0;
            node        <= 2'd0;
            wait_cnt    <= '0;
            eng_layer   <= 1'b0;
            eng_op      <= '0;
            out_vec     <= '0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            state    <= state_nx;
            layer    <= layer_nx;
            node     <= node_nx;
            wait_cnt <= (state == S_WAIT && !eng_done) ? wait_cnt + 1'b1 : '0;
            // Operands are registered on entry to ISSUE so they stay frozen
            // for the whole ISSUE/WAIT window.
            if (state_nx == S_ISSUE) begin
                eng_layer <= layer_nx;
                eng_op    <= op_nx;
            end
            if (state == S_WAIT && eng_done && layer) begin
                out_vec[node*40      +: 20] <= eng_res[19:0];
                out_vec[node*40 + 20 +: 20] <= eng_res[39:20];
            end
            if (in_ready && state != S_IDLE)
                err_overrun <= 1'b1;
            if (timeout_hit)
                err_timeout <= 1'b1;
        end
    end

    // Feature frame and hidden-layer buffers (no reset needed)
    always_ff @(posedge clk) begin
        if (state == S_IDLE && in_ready)
            x_buf <= x_in;
        if (state == S_WAIT && eng_done && !layer) begin
            for (int unsigned f = 0; f < 4; f++)
                hidden[node][f] <= eng_res[f*13 +: 13];
        end
    end

    // State-decoded strobes
    always_comb begin
        eng_req   = (state == S_ISSUE);
        out_valid = (state == S_DONE);
        busy      = (state != S_IDLE);
    end

endmodule

// File: tb/tb_gnn_layer_sched.sv
// Self-checking bench for gnn_layer_sched: a behavioural engine with
// configurable latency answers jobs; a graph-level reference model predicts
// operands and outputs.
module tb_gnn_layer_sched;

    localparam int TIMEOUT = 64;
    localparam int OPW     = 15;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_ready;
    logic [79:0]      x_in;
    logic             eng_req;
    logic             eng_layer;
    logic [4*OPW-1:0] eng_op;
    logic             eng_done;
    logic [51:0]      eng_res;
    logic [159:0]     out_vec;
    logic             out_valid;
    logic             busy;
    logic             err_timeout;
    logic             err_overrun;

    always #5 clk = ~clk;

    gnn_layer_sched #(.TIMEOUT(TIMEOUT), .OPW(OPW)) dut (
        .clk(clk), .rst(rst), .in_ready(in_ready), .x_in(x_in),
        .eng_req(eng_req), .eng_layer(eng_layer), .eng_op(eng_op),
        .eng_done(eng_done), .eng_res(eng_res), .out_vec(out_vec),
        .out_valid(out_valid), .busy(busy),
        .err_timeout(err_timeout), .err_overrun(err_overrun)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model (graph level) ----------------
    int           nb [4][3] = '{'{0, 1, 2}, '{0, 1, 3}, '{0, 2, 3}, '{1, 2, 3}};
    logic [59:0]  exp_op  [8];
    logic [19:0]  exp_out [8];
    logic [159:0] last_out = '0;

    function automatic int feat(input logic [79:0] x, input int m, input int f);
        logic [4:0] b = x[(m*4+f)*5 +: 5];
        return int'($signed(b));
    endfunction

    task automatic build_model(input logic [79:0] x);
        int hid [4][4];
        for (int n = 0; n < 4; n++) begin
            exp_op[n] = '0;
            for (int f = 0; f < 4; f++) begin
                int s = 0;
                for (int j = 0; j < 3; j++) s += feat(x, nb[n][j], f);
                exp_op[n][f*15 +: 15] = 15'(s);
                hid[n][f] = (s < 0) ? 0 : s;
            end
        end
        for (int n = 0; n < 4; n++) begin
            exp_op[4+n] = '0;
            for (int f = 0; f < 4; f++) begin
                int s = 0;
                for (int j = 0; j < 3; j++) s += hid[nb[n][j]][f];
                exp_op[4+n][f*15 +: 15] = 15'(s);
                if (f < 2) exp_out[2*n+f] = 20'(s);
            end
        end
    endtask

    // ---------------- behavioural engine ----------------
    int          lat_cfg = 1;
    int          drop_job = -1;
    int          req_cnt = 0;
    int          op_unstable = 0;
    bit          inject_done = 1'b0;
    logic        req_layer_log [8];
    logic [59:0] req_op_log    [8];

    function automatic logic [51:0] engine_result(input logic layer, input logic [59:0] op);
        logic [51:0] r = '0;
        if (!layer) begin
            for (int f = 0; f < 4; f++) begin
                int v = int'($signed(op[f*15 +: 15]));
                if (v < 0) v = 0;
                r[f*13 +: 13] = 13'(v);
            end
        end else begin
            r[19:0]  = 20'($signed(op[14:0]));
            r[39:20] = 20'($signed(op[29:15]));
        end
        return r;
    endfunction

    initial begin
        int          cnt;
        bit          pend;
        logic [51:0] res;
        logic [59:0] cur_op;
        logic        cur_layer;
        pend = 1'b0; cnt = 0; res = '0; cur_op = '0; cur_layer = 1'b0;
        eng_done = 1'b0;
        eng_res  = '0;
        forever begin
            @(posedge clk); #1;
            eng_done = 1'b0;
            if (inject_done) begin
                eng_done    = 1'b1;
                eng_res     = 52'({$urandom, $urandom});
                inject_done = 1'b0;
            end
            if (pend) begin
                if (eng_op !== cur_op || eng_layer !== cur_layer) op_unstable++;
                cnt--;
                if (cnt == 0) begin
                    eng_done = 1'b1;
                    eng_res  = res;
                    pend     = 1'b0;
                end
            end
            if (eng_req) begin
                if (req_cnt < 8) begin
                    req_layer_log[req_cnt] = eng_layer;
                    req_op_log[req_cnt]    = eng_op;
                end
                cur_op    = eng_op;
                cur_layer = eng_layer;
                res       = engine_result(eng_layer, eng_op);
                if (req_cnt != drop_job) begin
                    pend = 1'b1;
                    cnt  = lat_cfg;
                end
                req_cnt++;
            end
        end
    end

    task automatic check_out(input string tag, input logic [159:0] expv);
        for (int k = 0; k < 8; k++)
            check_eq($sformatf("%s/out%0d", tag, k), 64'(out_vec[k*20 +: 20]), 64'(expv[k*20 +: 20]));
    endtask

    task automatic check_idle_zero(input string tag);
        check_eq({tag, "/eng_req"},   64'(eng_req),   64'(0));
        check_eq({tag, "/eng_layer"}, 64'(eng_layer), 64'(0));
        check_eq({tag, "/eng_op"},    64'(eng_op),    64'(0));
        check_eq({tag, "/out_valid"}, 64'(out_valid), 64'(0));
        check_eq({tag, "/busy"},      64'(busy),      64'(0));
        check_eq({tag, "/err_to"},    64'(err_timeout), 64'(0));
        check_eq({tag, "/err_ov"},    64'(err_overrun), 64'(0));
        check_out(tag, '0);
    endtask

    // mode: 0 normal, 1 overrun pulses, 2 engine drops job 3, 3 reset mid-run
    task automatic run_frame(input logic [79:0] x, input int lat, input int mode, input string tag);
        int          cyc;
        bit          seen_valid;
        logic [159:0] expv;
        lat_cfg     = lat;
        drop_job    = (mode == 2) ? 3 : -1;
        req_cnt     = 0;
        op_unstable = 0;
        build_model(x);
        expv = '0;
        for (int k = 0; k < 8; k++) expv[k*20 +: 20] = exp_out[k];
        x_in     = x;
        in_ready = 1'b1;
        @(posedge clk); #1;
        in_ready   = 1'b0;
        x_in       = 80'({$urandom, $urandom, $urandom});
        cyc        = 1;
        seen_valid = 1'b0;
        check_eq({tag, "/busy_start"}, 64'(busy), 64'(1));
        while (cyc < 400) begin
            if (out_valid) begin seen_valid = 1'b1; break; end
            if (mode == 2 && !busy) break;
            if (mode == 3 && cyc == 7) break;
            @(posedge clk); #1;
            cyc++;
            in_ready = (mode == 1 && cyc == 5);
        end
        in_ready = 1'b0;
        if (mode == 0 || mode == 1) begin
            check_eq({tag, "/valid_seen"}, 64'(seen_valid), 64'(1));
            check_eq({tag, "/latency"}, 64'(cyc), 64'(1 + 8*(1+lat)));
            check_out(tag, expv);
            check_eq({tag, "/req_cnt"}, 64'(req_cnt), 64'(8));
            check_eq({tag, "/op_stable"}, 64'(op_unstable), 64'(0));
            for (int j = 0; j < 8; j++) begin
                check_eq($sformatf("%s/layer%0d", tag, j), 64'(req_layer_log[j]), 64'(j >= 4));
                check_eq($sformatf("%s/op%0d", tag, j), 64'(req_op_log[j]), 64'(exp_op[j]));
            end
            if (mode == 1) begin
                in_ready = 1'b1;
                x_in     = ~x;
            end
            @(posedge clk); #1;
            in_ready = 1'b0;
            check_eq({tag, "/valid_pulse"}, 64'(out_valid), 64'(0));
            check_eq({tag, "/busy_end"}, 64'(busy), 64'(0));
            if (mode == 1) check_eq({tag, "/err_overrun"}, 64'(err_overrun), 64'(1));
            repeat (2) @(posedge clk);
            #1;
            check_out({tag, "/hold"}, expv);
            last_out = expv;
        end else if (mode == 2) begin
            check_eq({tag, "/no_valid"}, 64'(seen_valid), 64'(0));
            check_eq({tag, "/abort_cyc"}, 64'(cyc), 64'(1 + 3*(1+lat) + 1 + TIMEOUT));
            check_eq({tag, "/err_timeout"}, 64'(err_timeout), 64'(1));
            check_eq({tag, "/req_cnt"}, 64'(req_cnt), 64'(4));
            check_out(tag, last_out);
        end else begin
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            last_out = '0;
            check_idle_zero({tag, "/after_rst"});
            inject_done = 1'b1;
            repeat (3) @(posedge clk);
            #1;
            check_eq({tag, "/stale_busy"}, 64'(busy), 64'(0));
            check_eq({tag, "/stale_req"}, 64'(eng_req), 64'(0));
            check_out({tag, "/stale"}, '0);
        end
    endtask

    initial begin
        logic [79:0]  x;
        logic [59:0]  op_extreme;
        rst = 1'b1; in_ready = 1'b0; x_in = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_idle_zero("reset");

        // nominal: node n features all n+1
        for (int n = 0; n < 4; n++)
            for (int f = 0; f < 4; f++) x[(n*4+f)*5 +: 5] = 5'(n + 1);
        run_frame(x, 1, 0, "nominal");
        check_eq("nominal/out0_21", 64'(out_vec[19:0]),    64'(21));
        check_eq("nominal/out6_24", 64'(out_vec[139:120]), 64'(24));

        // extremes: all features -16
        x = {16{5'b10000}};
        run_frame(x, 1, 0, "extreme");
        op_extreme = {4{15'h7FD0}};
        check_eq("extreme/op0_const", 64'(req_op_log[0]), 64'(op_extreme));

        run_frame(x, 1, 0, "extreme_b");
        for (int n = 0; n < 4; n++)
            for (int f = 0; f < 4; f++) x[(n*4+f)*5 +: 5] = 5'(n + 1);
        run_frame(x, 5, 0, "lat5");

        for (int i = 0; i < 6; i++) begin
            x = 80'({$urandom, $urandom, $urandom});
            run_frame(x, int'($urandom_range(1, 4)), 0, $sformatf("rand%0d", i));
        end

        run_frame(80'({$urandom, $urandom, $urandom}), 1, 1, "overrun");
        run_frame(80'({$urandom, $urandom, $urandom}), 1, 2, "timeout");
        run_frame(80'({$urandom, $urandom, $urandom}), 2, 0, "post_timeout");
        check_eq("post_timeout/sticky", 64'(err_timeout), 64'(1));

        run_frame(80'({$urandom, $urandom, $urandom}), 1, 3, "midreset");
        run_frame(80'({$urandom, $urandom, $urandom}), 3, 0, "post_reset");
        check_eq("post_reset/err_to", 64'(err_timeout), 64'(0));
        check_eq("post_reset/err_ov", 64'(err_overrun), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
        $fatal(1);
    end

endmodule
